prefetcher_ar_arbiter: RTL and testbench
========================================

// Module: prefetcher_ar_arbiter
// PURPOSE
//  Merges the DDR-side AR channels of NUM_SLICES prefetcher slices into the single master AR port to DDR.
//  Sits directly downstream of each slice controller's m_ar_* outputs.
//  Round-robin grants, one registered output stage, global outstanding-burst throttle counted from R-last beats.
//  R data is broadcast by the fabric; slices filter by ID, so this block only observes R.
// PARAMETERS
//  NUM_SLICES       4   number of slice requesters (>=2)
//  ADDR_BITS        64  address width
//  BURST_LEN_WIDTH  8   AR len width
//  TID_WIDTH        8   AR/R id width
//  OUTST_WIDTH      6   outstanding counter width
// PORTS
//  clk                 in   1                     clock
//  resetN              in   1                     asynchronous, active-low reset
//  en                  in   1                     global enable; low = freeze
//  sl_ar_valid         in   NUM_SLICES            per-slice AR valid
//  sl_ar_ready         out  NUM_SLICES            per-slice AR ready (one-hot or zero)
//  sl_ar_addr          in   NUM_SLICES*ADDR_BITS  per-slice address, slice i at [i*ADDR_BITS +: ADDR_BITS]
//  sl_ar_len           in   NUM_SLICES*BURST_LEN_WIDTH  per-slice burst len
//  sl_ar_id            in   NUM_SLICES*TID_WIDTH  per-slice id
//  sl_ar_isPrefetch    in   NUM_SLICES            1 = prefetch request, 0 = demand request
//  m_ar_valid          out  1                     DDR AR valid (registered)
//  m_ar_ready          in   1                     DDR AR ready
//  m_ar_addr/len/id    out  ADDR_BITS/BURST_LEN_WIDTH/TID_WIDTH  registered payload
//  m_r_valid, m_r_ready, m_r_last  in  1          observed R handshake and last beat
//  crs_maxOutstanding  in   OUTST_WIDTH           outstanding-burst limit; 0 blocks all grants
//  outstandingCnt      out  OUTST_WIDTH           current outstanding bursts
//  err_underflow       out  1                     sticky: R-last seen with outstandingCnt==0
// BEHAVIOUR
//  - Reset: state ST_ARB_IDLE; m_ar_valid=0; m_ar_addr/len/id=0; outstandingCnt=0; err_underflow=0.
//    lastGrant=NUM_SLICES-1, so slice 0 is granted first. sl_ar_ready=0 while resetN low.
//  - canGrant = en & (st==ST_ARB_IDLE) & (outstandingCnt < crs_maxOutstanding).
//  - Grant: winner = first valid slice scanning from lastGrant+1, wrapping modulo NUM_SLICES.
//    sl_ar_ready[winner] = canGrant & sl_ar_valid[winner], driven combinationally in the same cycle; all other readys 0.
//  - On slice handshake: latch winner payload into m_ar_*; m_ar_valid<=1; lastGrant<=winner; next state ST_ARB_HOLD.
//    Latency: slice handshake -> m_ar_valid high on the next edge (1 cycle).
//  - ST_ARB_HOLD: m_ar_valid and payload are stable until m_ar_valid&m_ar_ready.
//    On that handshake: m_ar_valid<=0, go to ST_ARB_IDLE. No new grant in the handshake cycle.
//    Throughput is therefore 1 AR every 2 cycles minimum.
//  - Counter: +1 on m_ar handshake; -1 on m_r_valid&m_r_ready&m_r_last.
//    Both in one cycle: unchanged. Decrement at 0: hold 0, set err_underflow.
//    Increment at all-ones: hold and set err_underflow; cannot occur when crs_maxOutstanding is below all-ones.
//  - crs_maxOutstanding lowered below outstandingCnt: grants stop until drained; the counter is untouched.
//  - en low: state, registers and counter hold, all sl_ar_ready=0.
//    m_ar_valid stays high if in HOLD (AXI: valid never drops before ready).
//    An m_ar handshake or R-last occurring while en is low is still counted.
//  - Reset mid-HOLD: the request is dropped. Upstream reset is a system-level requirement.
// CONFIGURATION
//  PR_ARB_DEMAND_PRIO_EN defined:
//    - Round-robin runs among valid demand slices (isPrefetch=0) only.
//    - Prefetch slices are eligible only when no demand is valid.
//    - A single lastGrant pointer is shared between both classes.
//  Undefined: sl_ar_isPrefetch is ignored; pure round-robin.
// STRUCTURE
//  - Package prefetcher_arb_pkg: arb_state_t enum {ST_ARB_IDLE, ST_ARB_HOLD}; function idxWidth(n)=$clog2(n).
//  - Sub-module pr_rr_pick (combinational):
//    - Inputs: req vector, lastGrant index.
//    - Outputs: one-hot grant, grant index, anyReq.
//    - Instantiated once, fed with the demand-filtered or raw request vector.
// TESTING
//  - Reset, then slices 0..3 all valid with crs_maxOutstanding=8 ->
//    grants 0,1,2,3,0, one per 2 cycles with m_ar_ready=1, payloads match.
//  - m_ar_ready held low 5 cycles in HOLD -> m_ar_valid/addr stable, no sl_ar_ready asserted.
//  - crs_maxOutstanding=2, 3 requests, no R ->
//    2 issued, 3rd stalls; one R-last -> 3rd issues, outstandingCnt returns to 2.
//  - AR handshake and R-last in the same cycle with cnt=1 -> cnt stays 1.
//    R-last with cnt=0 -> cnt 0, err_underflow=1.
//  - PR_ARB_DEMAND_PRIO_EN: slice1 prefetch and slice2 demand both valid -> slice2 granted;
//    slice1 granted only after slice2 drops.
//  - resetN pulsed low mid-HOLD -> m_ar_valid=0 asynchronously, cnt=0, next grant to slice 0.

Source files
------------

// File: rtl/prefetcher_ar_arbiter_pkg.sv
// Shared types for the prefetcher AR arbiter: FSM state encoding and index-width helper.
package prefetcher_arb_pkg;

  typedef enum logic {ST_ARB_IDLE, ST_ARB_HOLD} arb_state_t;

  function automatic int idxWidth(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/prefetcher_ar_arbiter_pr_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from last_grant+1, wrapping.
module pr_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IW'(idx);
      end
    end
  end

  assign any_req = found;

endmodule

// File: rtl/prefetcher_ar_arbiter.sv
// Merges per-slice AR channels into one registered DDR AR port with round-robin and an outstanding-burst throttle.
// Optional build macro PR_ARB_DEMAND_PRIO_EN: demand requests win over prefetch requests.
module prefetcher_ar_arbiter
  import prefetcher_arb_pkg::*;
#(
  parameter int NUM_SLICES      = 4,
  parameter int ADDR_BITS       = 64,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int OUTST_WIDTH     = 6
) (
  input  logic                                  clk,
  input  logic                                  resetN,
  input  logic                                  en,
  input  logic [NUM_SLICES-1:0]                 sl_ar_valid,
  output logic [NUM_SLICES-1:0]                 sl_ar_ready,
  input  logic [NUM_SLICES*ADDR_BITS-1:0]       sl_ar_addr,
  input  logic [NUM_SLICES*BURST_LEN_WIDTH-1:0] sl_ar_len,
  input  logic [NUM_SLICES*TID_WIDTH-1:0]       sl_ar_id,
  input  logic [NUM_SLICES-1:0]                 sl_ar_isPrefetch,
  output logic                                  m_ar_valid,
  input  logic                                  m_ar_ready,
  output logic [ADDR_BITS-1:0]                  m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
  output logic [TID_WIDTH-1:0]                  m_ar_id,
  input  logic                                  m_r_valid,
  input  logic                                  m_r_ready,
  input  logic                                  m_r_last,
  input  logic [OUTST_WIDTH-1:0]                crs_maxOutstanding,
  output logic [OUTST_WIDTH-1:0]                outstandingCnt,
  output logic                                  err_underflow,
  output arb_state_t                            dbg_state
);

  localparam int            IW       = idxWidth(NUM_SLICES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLICES - 1);

  arb_state_t            st;
  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         grant_idx;
  logic [NUM_SLICES-1:0] req;
  logic [NUM_SLICES-1:0] grant;
  logic                  any_req;
  logic                  can_grant;
  logic                  slice_hs;
  logic                  ar_hs;
  logic                  r_last_hs;

  // Handshakes: a transfer happens on any edge where valid and ready are both high;
  // valid never depends on ready, and once raised it holds with stable payload until the transfer.
`ifdef PR_ARB_DEMAND_PRIO_EN
  logic [NUM_SLICES-1:0] demand;
  assign demand = sl_ar_valid & ~sl_ar_isPrefetch;
  assign req    = (|demand) ? demand : sl_ar_valid;
`else
  logic unused_is_prefetch;
  assign unused_is_prefetch = ^sl_ar_isPrefetch;
  assign req                = sl_ar_valid;
`endif

  pr_rr_pick #(.N(NUM_SLICES), .IW(IW)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  assign can_grant   = resetN & en & (st == ST_ARB_IDLE) & (outstandingCnt < crs_maxOutstanding);
  assign slice_hs    = can_grant & any_req;
  assign sl_ar_ready = slice_hs ? grant : '0;
  assign ar_hs       = m_ar_valid & m_ar_ready;
  assign r_last_hs   = m_r_valid & m_r_ready & m_r_last;
  assign dbg_state   = st;

  // The DDR handshake completes even with en low: the slave has taken the burst, so valid must drop.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st         <= ST_ARB_IDLE;
      m_ar_valid <= 1'b0;
      m_ar_addr  <= '0;
      m_ar_len   <= '0;
      m_ar_id    <= '0;
      last_grant <= LAST_IDX;
    end else begin
      case (st)
        ST_ARB_IDLE: begin
          if (slice_hs) begin
            m_ar_addr  <= sl_ar_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
            m_ar_len   <= sl_ar_len[grant_idx*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
            m_ar_id    <= sl_ar_id[grant_idx*TID_WIDTH +: TID_WIDTH];
            m_ar_valid <= 1'b1;
            last_grant <= grant_idx;
            st         <= ST_ARB_HOLD;
          end
        end
        ST_ARB_HOLD: begin
          if (ar_hs) begin
            m_ar_valid <= 1'b0;
            st         <= ST_ARB_IDLE;
          end
        end
        default: st <= ST_ARB_IDLE;
      endcase
    end
  end

  // Outstanding bursts: issue and completion in the same cycle cancel out.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      outstandingCnt <= '0;
      err_underflow  <= 1'b0;
    end else begin
      case ({ar_hs, r_last_hs})
        2'b10: begin
          if (&outstandingCnt) err_underflow <= 1'b1;
          else                 outstandingCnt <= outstandingCnt + 1'b1;
        end
        2'b01: begin
          if (outstandingCnt == '0) err_underflow <= 1'b1;
          else                      outstandingCnt <= outstandingCnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetcher_ar_arbiter.sv
// Self-checking bench for prefetcher_ar_arbiter: directed scenarios plus randomized traffic against a rule-level model.
`timescale 1ns/1ps
module tb_prefetcher_ar_arbiter;
  import prefetcher_arb_pkg::*;

  localparam int NS = 4, AW = 64, LW = 8, TW = 8, OW = 6;
`ifdef PR_ARB_DEMAND_PRIO_EN
  localparam bit DEMAND_PRIO = 1'b1;
`else
  localparam bit DEMAND_PRIO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetN, en;
  logic [NS-1:0]     sl_ar_valid, sl_ar_ready, sl_ar_isPrefetch;
  logic [NS*AW-1:0]  sl_ar_addr;
  logic [NS*LW-1:0]  sl_ar_len;
  logic [NS*TW-1:0]  sl_ar_id;
  logic              m_ar_valid, m_ar_ready;
  logic [AW-1:0]     m_ar_addr;
  logic [LW-1:0]     m_ar_len;
  logic [TW-1:0]     m_ar_id;
  logic              m_r_valid, m_r_ready, m_r_last;
  logic [OW-1:0]     crs_maxOutstanding, outstandingCnt;
  logic              err_underflow;
  arb_state_t        dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  prefetcher_ar_arbiter #(
    .NUM_SLICES(NS), .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(TW), .OUTST_WIDTH(OW)
  ) dut (
    .clk(clk), .resetN(resetN), .en(en),
    .sl_ar_valid(sl_ar_valid), .sl_ar_ready(sl_ar_ready), .sl_ar_addr(sl_ar_addr),
    .sl_ar_len(sl_ar_len), .sl_ar_id(sl_ar_id), .sl_ar_isPrefetch(sl_ar_isPrefetch),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
    .crs_maxOutstanding(crs_maxOutstanding), .outstandingCnt(outstandingCnt),
    .err_underflow(err_underflow), .dbg_state(dbg_state)
  );

  int checks = 0, failures = 0;

  logic [AW-1:0] s_addr[NS];
  logic [LW-1:0] s_len[NS];
  logic [TW-1:0] s_id[NS];

  // scoreboard
  logic [AW-1:0] exp_q[$];
  int            grant_q[$];

  int            mdl_last, mdl_cnt;
  bit            mdl_err, mdl_hold;
  logic [AW-1:0] mdl_addr;
  logic [LW-1:0] mdl_len;
  logic [TW-1:0] mdl_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gq(input int i);
    return (i < grant_q.size()) ? grant_q[i] : -1;
  endfunction

  // driver tasks
  task automatic apply();
    for (int i = 0; i < NS; i++) begin
      sl_ar_addr[i*AW +: AW] = s_addr[i];
      sl_ar_len[i*LW +: LW]  = s_len[i];
      sl_ar_id[i*TW +: TW]   = s_id[i];
    end
  endtask

  task automatic new_payloads();
    for (int i = 0; i < NS; i++) begin
      s_addr[i] = {$urandom, $urandom};
      s_len[i]  = LW'($urandom_range(0, 255));
      s_id[i]   = TW'($urandom_range(0, 255));
    end
    apply();
  endtask

  task automatic set_r(input bit on);
    m_r_valid = on;
    m_r_ready = on;
    m_r_last  = on;
  endtask

  task automatic model_reset();
    mdl_last = NS - 1;
    mdl_cnt  = 0;
    mdl_err  = 1'b0;
    mdl_hold = 1'b0;
    mdl_addr = '0;
    mdl_len  = '0;
    mdl_id   = '0;
    exp_q.delete();
  endtask

  // Winner by the round-robin rule, or -1 when nobody is eligible.
  function automatic int pick(input logic [NS-1:0] v, input logic [NS-1:0] pf, input int last);
    logic [NS-1:0] elig;
    elig = v;
    if (DEMAND_PRIO && ((v & ~pf) != '0)) elig = v & ~pf;
    for (int off = 1; off <= NS; off++)
      if (elig[(last + off) % NS]) return (last + off) % NS;
    return -1;
  endfunction

  // One clock per iteration: check outputs at negedge, advance the model at posedge.
  task automatic cycle(input int n);
    for (int c = 0; c < n; c++) begin
      int            w;
      logic [NS-1:0] exp_rdy;
      bit            ar_hs, rl;
      @(negedge clk);
      w = (resetN && en && !mdl_hold && (mdl_cnt < int'(crs_maxOutstanding)))
          ? pick(sl_ar_valid, sl_ar_isPrefetch, mdl_last) : -1;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("sl_ar_ready", 64'(sl_ar_ready), 64'(exp_rdy));
      chk("m_ar_valid", 64'(m_ar_valid), 64'(mdl_hold));
      chk("dbg_state", 64'(dbg_state), 64'(mdl_hold ? ST_ARB_HOLD : ST_ARB_IDLE));
      if (mdl_hold) begin
        chk("m_ar_addr", m_ar_addr, mdl_addr);
        chk("m_ar_len", 64'(m_ar_len), 64'(mdl_len));
        chk("m_ar_id", 64'(m_ar_id), 64'(mdl_id));
      end
      chk("outstandingCnt", 64'(outstandingCnt), 64'(mdl_cnt));
      chk("err_underflow", 64'(err_underflow), 64'(mdl_err));
      ar_hs = mdl_hold && m_ar_ready;
      rl    = m_r_valid && m_r_ready && m_r_last;
      if (ar_hs) chk("sb_addr", m_ar_addr, (exp_q.size() > 0) ? exp_q.pop_front() : '1);
      @(posedge clk);
      if (resetN) begin
        if (ar_hs) mdl_hold = 1'b0;
        if (w >= 0) begin
          mdl_hold = 1'b1;
          mdl_addr = s_addr[w];
          mdl_len  = s_len[w];
          mdl_id   = s_id[w];
          mdl_last = w;
          exp_q.push_back(s_addr[w]);
          grant_q.push_back(w);
        end
        if (ar_hs && !rl) begin
          if (mdl_cnt == (1 << OW) - 1) mdl_err = 1'b1;
          else mdl_cnt++;
        end else if (rl && !ar_hs) begin
          if (mdl_cnt == 0) mdl_err = 1'b1;
          else mdl_cnt--;
        end
      end
      #1;
    end
  endtask

  initial begin
    resetN = 1'b0; en = 1'b1; sl_ar_valid = '1; sl_ar_isPrefetch = '0;
    m_ar_ready = 1'b1; set_r(1'b0); crs_maxOutstanding = 6'd8;
    sl_ar_addr = '0; sl_ar_len = '0; sl_ar_id = '0;
    new_payloads();
    model_reset();

    // reset state
    #2;
    chk("rst_m_ar_valid", 64'(m_ar_valid), 64'(0));
    chk("rst_m_ar_addr", m_ar_addr, 64'(0));
    chk("rst_cnt", 64'(outstandingCnt), 64'(0));
    chk("rst_err", 64'(err_underflow), 64'(0));
    chk("rst_ready", 64'(sl_ar_ready), 64'(0));
    cycle(2);
    resetN = 1'b1;

    // all slices valid: grants 0,1,2,3,0 one per two cycles
    grant_q.delete();
    cycle(10);
    chk("rr_count", 64'(grant_q.size()), 64'(5));
    chk("rr_g0", 64'(gq(0)), 64'(0));
    chk("rr_g1", 64'(gq(1)), 64'(1));
    chk("rr_g2", 64'(gq(2)), 64'(2));
    chk("rr_g3", 64'(gq(3)), 64'(3));
    chk("rr_g4", 64'(gq(4)), 64'(0));
    chk("rr_cnt", 64'(outstandingCnt), 64'(5));
    sl_ar_valid = '0; set_r(1'b1);
    cycle(5);
    set_r(1'b0);
    chk("drain_cnt", 64'(outstandingCnt), 64'(0));

    // m_ar_ready low in HOLD: payload stable, no readys
    sl_ar_valid = 4'b0010; m_ar_ready = 1'b0;
    cycle(1);
    sl_ar_valid = '1;
    cycle(5);
    chk("hold_valid", 64'(m_ar_valid), 64'(1));
    chk("hold_addr", m_ar_addr, s_addr[1]);
    m_ar_ready = 1'b1; sl_ar_valid = '0;
    cycle(2);
    set_r(1'b1); cycle(1); set_r(1'b0);

    // throttle at 2 outstanding
    crs_maxOutstanding = 6'd2; sl_ar_valid = 4'b0111; grant_q.delete();
    cycle(8);
    chk("thr_grants", 64'(grant_q.size()), 64'(2));
    chk("thr_cnt", 64'(outstandingCnt), 64'(2));
    set_r(1'b1); cycle(1); set_r(1'b0);
    cycle(4);
    sl_ar_valid = '0;
    chk("thr_grants3", 64'(grant_q.size()), 64'(3));
    chk("thr_cnt2", 64'(outstandingCnt), 64'(2));

    // same-cycle issue and completion, then underflow
    crs_maxOutstanding = 6'd8;
    set_r(1'b1); cycle(1); set_r(1'b0);
    sl_ar_valid = 4'b0001; m_ar_ready = 1'b0;
    cycle(1);
    sl_ar_valid = '0; m_ar_ready = 1'b1; set_r(1'b1);
    cycle(1);
    chk("same_cycle_cnt", 64'(outstandingCnt), 64'(1));
    m_ar_ready = 1'b0;
    cycle(2);
    set_r(1'b0); m_ar_ready = 1'b1;
    cycle(1);
    chk("uf_cnt", 64'(outstandingCnt), 64'(0));
    chk("uf_err", 64'(err_underflow), 64'(1));

    // demand vs prefetch
    sl_ar_valid = 4'b0110; sl_ar_isPrefetch = 4'b0010; grant_q.delete();
    cycle(4);
    sl_ar_valid = 4'b0010;
    cycle(2);
    sl_ar_valid = '0; sl_ar_isPrefetch = '0;
`ifdef PR_ARB_DEMAND_PRIO_EN
    chk("prio_g0", 64'(gq(0)), 64'(2));
    chk("prio_g1", 64'(gq(1)), 64'(2));
    chk("prio_g2", 64'(gq(2)), 64'(1));
`endif
    set_r(1'b1); cycle(3); set_r(1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      en               = ($urandom_range(0, 9) != 0);
      sl_ar_valid      = NS'($urandom);
      sl_ar_isPrefetch = NS'($urandom);
      m_ar_ready       = ($urandom_range(0, 3) != 0);
      m_r_valid        = ($urandom_range(0, 2) == 0);
      m_r_ready        = ($urandom_range(0, 3) != 0);
      m_r_last         = ($urandom_range(0, 1) == 0);
      if (i % 50 == 0) crs_maxOutstanding = OW'($urandom_range(0, 10));
      if (i % 7 == 0) new_payloads();
      cycle(1);
    end
    en = 1'b1; set_r(1'b0); sl_ar_isPrefetch = '0;

    // reset asserted mid-HOLD
    crs_maxOutstanding = 6'd40; m_ar_ready = 1'b0; sl_ar_valid = '0;
    cycle(2);
    m_ar_ready = 1'b1; cycle(2); m_ar_ready = 1'b0;
    sl_ar_valid = 4'b0100;
    cycle(1);
    #2;
    resetN = 1'b0;
    #1;
    chk("arst_valid", 64'(m_ar_valid), 64'(0));
    chk("arst_cnt", 64'(outstandingCnt), 64'(0));
    chk("arst_err", 64'(err_underflow), 64'(0));
    chk("arst_ready", 64'(sl_ar_ready), 64'(0));
    model_reset();
    cycle(1);
    resetN = 1'b1; sl_ar_valid = '1; m_ar_ready = 1'b1; grant_q.delete();
    cycle(2);
    chk("arst_first_grant", 64'(gq(0)), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
